plic_gateway: RTL and testbench
===============================

Name: plic_gateway

Overview:
- Interrupt gateway directly upstream of the PLIC core.
- Synchronises raw peripheral interrupt lines (uart = source 1, gpio = source 2, others spare), converts level or edge requests into single pending requests, and holds each source off until its claim/complete cycle finishes.
- Drives the PLIC pending vector and takes claim/complete pulses from the PLIC's claim/complete register logic.

Parameters:
- NSRC, 7, number of source slots including reserved source 0.
- IDW, 3, width of claim/complete IDs; must satisfy 2**IDW >= NSRC.
- CNTW, 2, width of the per-source queued-edge counter; saturates at 2**CNTW-1.

Ports:
- wb_clk_i  input  1  system clock, all state on rising edge.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- irq_src_i  input  NSRC  raw interrupt lines, asynchronous to wb_clk_i; bit 0 ignored.
- edge_mode_i  input  NSRC  per source: 1 = rising-edge triggered, 0 = level (active-high); quasi-static.
- claim_i  input  1  one-cycle claim strobe.
- claim_id_i  input  IDW  source ID being claimed.
- complete_i  input  1  one-cycle completion strobe.
- complete_id_i  input  IDW  source ID being completed.
- ovf_clr_i  input  1  one-cycle pulse that clears all overflow_o bits.
- pending_o  output  NSRC  registered; bit i high while source i is PENDING.
- in_service_o  output  NSRC  registered; bit i high while source i is CLAIMED.
- overflow_o  output  NSRC  sticky; an edge was lost because the counter was saturated.

Behaviour:
- Reset (async assert, sync-safe release): all outputs 0; synchroniser flops, edge-history flops and counters 0; every source IDLE.
- Synchroniser: two flops per source (s1, s2), plus history flop s3. edge_now[i] = s2 & ~s3. level_now[i] = s2.
- Source 0 is held IDLE permanently; its output bits are constant 0.
- Per-source FSM (i = 1..NSRC-1), states IDLE, PENDING, CLAIMED:
  - IDLE -> PENDING on level mode with level_now=1, or edge mode with (count>0 or edge_now=1).
  - PENDING -> CLAIMED on claim_i=1 and claim_id_i==i.
  - CLAIMED -> IDLE on complete_i=1 and complete_id_i==i.
  - An asserted level re-pends on the cycle after IDLE is re-entered, never in the same cycle as complete.
- Latency: an irq_src_i change meeting setup before edge k gives pending_o=1 after edge k+2, in both modes.
- Edge counter (edge mode only) counts edges not yet forwarded:
  - edge_now in PENDING or CLAIMED: count+1.
  - IDLE->PENDING caused by count>0 without edge_now: count-1.
  - IDLE->PENDING with edge_now=1: count unchanged (the edge is consumed directly).
  - edge_now while count==max and not consumed: count stays max, overflow_o[i] set.
- Counter in level mode: forced to 0. Switching edge_mode_i while a source is not IDLE is undefined.
- ovf_clr_i clears all overflow bits. A simultaneous new overflow wins (the bit stays set).
- Ignored strobes, with no state change:
  - claim of ID 0, ID >= NSRC, or a source not PENDING.
  - complete of ID 0, ID >= NSRC, or a source not CLAIMED.
- claim and complete in the same cycle act independently. Same ID in both cannot conflict because the states are exclusive.
- Level deasserted while PENDING: the request stays PENDING until claimed (latched). Complete still required after claim.
- Reset asserted mid-cycle (any state): immediate return to reset values; edges seen before reset are discarded.

Test Plan:
- Level, source 1: raise irq_src_i[1] before edge 0 -> pending_o=7'b0000010 after edge 2. claim id 1 -> pending 0, in_service_o[1]=1. complete id 1 with line still high -> IDLE one cycle, then pending_o[1]=1 again.
- Edge, source 2: three single-cycle pulses spaced 4 cycles while CLAIMED, CNTW=2 -> count=3, overflow_o=0. Fourth pulse -> overflow_o[2]=1. Three complete/claim rounds -> three re-pends, then IDLE. ovf_clr_i -> overflow_o=0.
- Edge arriving in the same cycle as IDLE->PENDING -> counter unchanged, exactly one pending.
- Illegal strobes: claim id 0, id 7, id 3 while IDLE; complete id 1 while PENDING -> no change on any output.
- Simultaneous: source 1 CLAIMED, source 2 PENDING; claim id 2 and complete id 1 in the same cycle -> in_service_o=7'b0000100, pending_o[2]=0, source 1 IDLE.
- Reset asserted asynchronously mid-cycle while sources are PENDING with count=2 -> all outputs 0 before the next clock edge; after release, no pending until a new edge or level.

Source files
------------

// File: rtl/plic_gateway_if.sv
`default_nettype none
//==============================================================================
// Module      : plic_gateway_if
// Description : Bundles the request lines, claim/complete strobes and pending /
//               in-service / overflow status exchanged between the PLIC
//               claim/complete logic (master) and the interrupt gateway (slave).
// Revision    : 1.0 - initial release
//==============================================================================
interface plic_gateway_if #(
   parameter int NSRC = 7,
   parameter int IDW  = 3
);
   logic [NSRC-1:0] irq_src_i;
   logic [NSRC-1:0] edge_mode_i;
   logic            claim_i;
   logic [IDW-1:0]  claim_id_i;
   logic            complete_i;
   logic [IDW-1:0]  complete_id_i;
   logic            ovf_clr_i;
   logic [NSRC-1:0] pending_o;
   logic [NSRC-1:0] in_service_o;
   logic [NSRC-1:0] overflow_o;

   modport master (
      output irq_src_i, edge_mode_i, claim_i, claim_id_i,
             complete_i, complete_id_i, ovf_clr_i,
      input  pending_o, in_service_o, overflow_o
   );

   modport slave (
      input  irq_src_i, edge_mode_i, claim_i, claim_id_i,
             complete_i, complete_id_i, ovf_clr_i,
      output pending_o, in_service_o, overflow_o
   );
endinterface
`default_nettype wire

// File: rtl/plic_gateway.sv
`default_nettype none
//==============================================================================
// Module      : plic_gateway
// Description : Interrupt gateway in front of the PLIC core. Synchronises raw
//               interrupt lines, turns level or edge requests into single
//               pending requests, queues surplus edges in a saturating counter
//               and holds each source off until its claim/complete finishes.
//               Source 0 is reserved and never requests. IDW must be wide
//               enough to address every source (2**IDW >= NSRC).
// Revision    : 1.0 - initial release
//==============================================================================
module plic_gateway #(
   parameter int NSRC = 7,
   parameter int IDW  = 3,
   parameter int CNTW = 2
) (
   input  wire logic     wb_clk_i,
   input  wire logic     wb_rst_i,
   plic_gateway_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_CLAIMED = 2'd2
   } state_t;

   localparam logic [CNTW-1:0] c_cnt_max = {CNTW{1'b1}};

   logic [NSRC-1:0] w_pending;
   logic [NSRC-1:0] w_in_service;
   logic [NSRC-1:0] w_overflow;

   // Reserved source 0 inputs are deliberately ignored.
   logic w_unused_src0;
   assign w_unused_src0 = bus.irq_src_i[0] ^ bus.edge_mode_i[0];

   // Reserved source 0 is permanently idle.
   assign w_pending[0]    = 1'b0;
   assign w_in_service[0] = 1'b0;
   assign w_overflow[0]   = 1'b0;

   generate
      for (genvar gi = 1; gi < NSRC; gi++) begin : g_src
         logic            r_s1;
         logic            r_s2;
         logic            r_s3;
         state_t          r_state;
         logic [CNTW-1:0] r_cnt;
         logic            r_pend;
         logic            r_serv;
         logic            r_ovf;
         logic            w_edge_mode;
         logic            w_edge_now;
         logic            w_claim_hit;
         logic            w_cmp_hit;

         assign w_edge_mode = bus.edge_mode_i[gi];
         assign w_edge_now  = r_s2 & ~r_s3;
         assign w_claim_hit = bus.claim_i    && (bus.claim_id_i    == IDW'(gi));
         assign w_cmp_hit   = bus.complete_i && (bus.complete_id_i == IDW'(gi));

         // Two-flop synchroniser plus history flop for rising-edge detection.
         always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
               r_s1 <= 1'b0;
               r_s2 <= 1'b0;
               r_s3 <= 1'b0;
            end else begin
               r_s1 <= bus.irq_src_i[gi];
               r_s2 <= r_s1;
               r_s3 <= r_s2;
            end
         end

         // Request state machine, queued-edge counter and sticky overflow.
         always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_pend  <= 1'b0;
               r_serv  <= 1'b0;
               r_ovf   <= 1'b0;
            end else begin
               // A clear is overridden by an overflow in the same cycle below.
               if (bus.ovf_clr_i) begin
                  r_ovf <= 1'b0;
               end

               case (r_state)
                  ST_IDLE: begin
                     if (w_edge_mode) begin
                        if (w_edge_now) begin
                           // Fresh edge is forwarded directly; queue untouched.
                           r_state <= ST_PENDING;
                           r_pend  <= 1'b1;
                        end else if (r_cnt != '0) begin
                           r_state <= ST_PENDING;
                           r_pend  <= 1'b1;
                           r_cnt   <= r_cnt - 1'b1;
                        end
                     end else if (r_s2) begin
                        r_state <= ST_PENDING;
                        r_pend  <= 1'b1;
                     end
                  end
                  ST_PENDING: begin
                     if (w_claim_hit) begin
                        r_state <= ST_CLAIMED;
                        r_pend  <= 1'b0;
                        r_serv  <= 1'b1;
                     end
                  end
                  ST_CLAIMED: begin
                     if (w_cmp_hit) begin
                        r_state <= ST_IDLE;
                        r_serv  <= 1'b0;
                     end
                  end
                  default: begin
                     r_state <= ST_IDLE;
                     r_pend  <= 1'b0;
                     r_serv  <= 1'b0;
                  end
               endcase

               // Edges arriving while busy are queued for later forwarding.
               if (w_edge_mode && (r_state != ST_IDLE) && w_edge_now) begin
                  if (r_cnt == c_cnt_max) begin
                     r_ovf <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               // Level-mode sources never queue anything.
               if (!w_edge_mode) begin
                  r_cnt <= '0;
               end
            end
         end

         assign w_pending[gi]    = r_pend;
         assign w_in_service[gi] = r_serv;
         assign w_overflow[gi]   = r_ovf;
      end
   endgenerate

   assign bus.pending_o    = w_pending;
   assign bus.in_service_o = w_in_service;
   assign bus.overflow_o   = w_overflow;

endmodule
`default_nettype wire

// File: tb/tb_plic_gateway.sv
`default_nettype none
//==============================================================================
// Module      : tb_plic_gateway
// Description : Self-checking bench for plic_gateway: a per-cycle vector table
//               for level-mode behaviour and illegal strobes, plus directed
//               sequences for edge queuing, overflow and asynchronous reset.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_plic_gateway;

   localparam int NSRC = 7;
   localparam int IDW  = 3;
   localparam int CNTW = 2;
   localparam int NVEC = 21;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   plic_gateway_if #(.NSRC(NSRC), .IDW(IDW)) bus ();

   plic_gateway #(.NSRC(NSRC), .IDW(IDW), .CNTW(CNTW)) u_dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] irq;
      logic       clm;
      logic [2:0] cid;
      logic       cmp;
      logic [2:0] pid;
      logic [6:0] ep;
      logic [6:0] es;
   } vec_t;

   vec_t tbl [NVEC];

   // Advance one clock; return 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [6:0] ep,
                        input logic [6:0] es, input logic [6:0] eo);
      n_tests++;
      if (bus.pending_o !== ep || bus.in_service_o !== es || bus.overflow_o !== eo) begin
         n_fail++;
         $display("FAIL %s: got pending=%b in_service=%b overflow=%b, want %b %b %b",
                  nm, bus.pending_o, bus.in_service_o, bus.overflow_o, ep, es, eo);
      end
   endtask

   task automatic do_claim(input logic [2:0] id);
      bus.claim_i    = 1'b1;
      bus.claim_id_i = id;
      tick();
      bus.claim_i    = 1'b0;
      bus.claim_id_i = 3'd0;
   endtask

   task automatic do_complete(input logic [2:0] id);
      bus.complete_i    = 1'b1;
      bus.complete_id_i = id;
      tick();
      bus.complete_i    = 1'b0;
      bus.complete_id_i = 3'd0;
   endtask

   task automatic pulse2();
      bus.irq_src_i[2] = 1'b1;
      tick();
      bus.irq_src_i[2] = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst               = 1'b1;
      bus.irq_src_i     = '0;
      bus.edge_mode_i   = '0;
      bus.claim_i       = 1'b0;
      bus.claim_id_i    = '0;
      bus.complete_i    = 1'b0;
      bus.complete_id_i = '0;
      bus.ovf_clr_i     = 1'b0;

      //            irq     clm   cid   cmp   pid   pending in_service
      tbl[0]  = '{7'h02, 1'b0, 3'd0, 1'b0, 3'd0, 7'h00, 7'h00};
      tbl[1]  = '{7'h02, 1'b0, 3'd0, 1'b0, 3'd0, 7'h00, 7'h00};
      tbl[2]  = '{7'h02, 1'b0, 3'd0, 1'b0, 3'd0, 7'h02, 7'h00};
      tbl[3]  = '{7'h03, 1'b0, 3'd0, 1'b0, 3'd0, 7'h02, 7'h00};
      tbl[4]  = '{7'h02, 1'b1, 3'd1, 1'b0, 3'd0, 7'h00, 7'h02};
      tbl[5]  = '{7'h02, 1'b0, 3'd0, 1'b1, 3'd1, 7'h00, 7'h00};
      tbl[6]  = '{7'h02, 1'b0, 3'd0, 1'b0, 3'd0, 7'h02, 7'h00};
      tbl[7]  = '{7'h02, 1'b0, 3'd0, 1'b1, 3'd1, 7'h02, 7'h00};
      tbl[8]  = '{7'h02, 1'b1, 3'd0, 1'b0, 3'd0, 7'h02, 7'h00};
      tbl[9]  = '{7'h02, 1'b1, 3'd7, 1'b0, 3'd0, 7'h02, 7'h00};
      tbl[10] = '{7'h02, 1'b1, 3'd3, 1'b1, 3'd0, 7'h02, 7'h00};
      tbl[11] = '{7'h06, 1'b1, 3'd1, 1'b0, 3'd0, 7'h00, 7'h02};
      tbl[12] = '{7'h06, 1'b0, 3'd0, 1'b0, 3'd0, 7'h00, 7'h02};
      tbl[13] = '{7'h04, 1'b0, 3'd0, 1'b0, 3'd0, 7'h04, 7'h02};
      tbl[14] = '{7'h04, 1'b1, 3'd2, 1'b1, 3'd1, 7'h00, 7'h04};
      tbl[15] = '{7'h04, 1'b0, 3'd0, 1'b0, 3'd0, 7'h00, 7'h04};
      tbl[16] = '{7'h00, 1'b0, 3'd0, 1'b1, 3'd2, 7'h00, 7'h00};
      tbl[17] = '{7'h00, 1'b0, 3'd0, 1'b0, 3'd0, 7'h04, 7'h00};
      tbl[18] = '{7'h00, 1'b1, 3'd2, 1'b0, 3'd0, 7'h00, 7'h04};
      tbl[19] = '{7'h00, 1'b0, 3'd0, 1'b1, 3'd2, 7'h00, 7'h00};
      tbl[20] = '{7'h00, 1'b0, 3'd0, 1'b0, 3'd0, 7'h00, 7'h00};

      // Reset state
      repeat (3) tick();
      check("reset", 7'h00, 7'h00, 7'h00);
      rst = 1'b0;

      // Level mode, illegal strobes and simultaneous claim/complete
      for (int i = 0; i < NVEC; i++) begin
         bus.irq_src_i     = tbl[i].irq;
         bus.claim_i       = tbl[i].clm;
         bus.claim_id_i    = tbl[i].cid;
         bus.complete_i    = tbl[i].cmp;
         bus.complete_id_i = tbl[i].pid;
         tick();
         check($sformatf("vec%0d", i), tbl[i].ep, tbl[i].es, 7'h00);
      end
      bus.claim_i    = 1'b0;
      bus.complete_i = 1'b0;
      bus.irq_src_i  = '0;

      // Edge mode on source 2: queue three edges, overflow on the fourth
      bus.edge_mode_i = 7'b0000100;
      tick();
      pulse2(); tick(); tick();
      check("edge first pend", 7'h04, 7'h00, 7'h00);
      do_claim(3'd2);
      check("edge claim", 7'h00, 7'h04, 7'h00);
      for (int k = 0; k < 3; k++) begin
         pulse2(); repeat (3) tick();
      end
      check("three queued", 7'h00, 7'h04, 7'h00);
      pulse2(); repeat (3) tick();
      check("fourth overflows", 7'h00, 7'h04, 7'h04);
      for (int r = 0; r < 3; r++) begin
         do_complete(3'd2);
         check($sformatf("round%0d idle", r), 7'h00, 7'h00, 7'h04);
         tick();
         check($sformatf("round%0d repend", r), 7'h04, 7'h00, 7'h04);
         do_claim(3'd2);
         check($sformatf("round%0d claim", r), 7'h00, 7'h04, 7'h04);
      end
      do_complete(3'd2);
      tick(); tick();
      check("queue drained", 7'h00, 7'h00, 7'h04);
      bus.ovf_clr_i = 1'b1;
      tick();
      bus.ovf_clr_i = 1'b0;
      check("ovf clear", 7'h00, 7'h00, 7'h00);

      // Edge arriving on the very cycle a queued request would be forwarded
      pulse2(); tick(); tick();
      check("consume pend", 7'h04, 7'h00, 7'h00);
      do_claim(3'd2);
      pulse2(); repeat (3) tick();
      bus.irq_src_i[2]  = 1'b1;
      tick();
      bus.irq_src_i[2]  = 1'b0;
      bus.complete_i    = 1'b1;
      bus.complete_id_i = 3'd2;
      tick();
      bus.complete_i    = 1'b0;
      bus.complete_id_i = 3'd0;
      check("consume idle", 7'h00, 7'h00, 7'h00);
      tick();
      check("consume edge direct", 7'h04, 7'h00, 7'h00);
      do_claim(3'd2); do_complete(3'd2); tick();
      check("consume queued one", 7'h04, 7'h00, 7'h00);
      do_claim(3'd2); do_complete(3'd2); tick(); tick();
      check("consume no extra", 7'h00, 7'h00, 7'h00);

      // Asynchronous reset with queued edges and a level request pending
      bus.irq_src_i[1] = 1'b1;
      pulse2(); tick(); tick();
      check("pre-reset pend", 7'h06, 7'h00, 7'h00);
      pulse2(); repeat (3) tick();
      pulse2(); repeat (3) tick();
      check("pre-reset count2", 7'h06, 7'h00, 7'h00);
      #2;
      rst = 1'b1;
      #1;
      check("async reset", 7'h00, 7'h00, 7'h00);
      bus.irq_src_i = '0;
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      check("post-reset quiet", 7'h00, 7'h00, 7'h00);
      bus.irq_src_i[1] = 1'b1;
      repeat (3) tick();
      check("post-reset level", 7'h02, 7'h00, 7'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
